serial_deserializer: RTL

Receives the 1 MHz serial bitstream on the 100 MHz system clock and assembles it into parallel words for frame memory. It sits directly upstream of the memory address generator: its one-cycle `done` pulse advances the write address, and `data_out` is the word written at that address. It handles line synchronisation, start-bit validation, mid-bit sampling, stop-bit checking and abort.

---
 rtl/serial_deserializer_pkg.sv | 15 +
 rtl/serial_deserializer_if.sv | 17 +
 rtl/serial_deserializer_sync_2ff.sv | 22 ++
 rtl/serial_deserializer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial receive path.
// Pure declarations: no timing, no flow control.
package serial_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 100;
  localparam int DATA_W_DEF       = 8;
  localparam int MEM_DEPTH        = 62500;
endpackage

// File: rtl/serial_deserializer_if.sv
// Line-side inputs and word-side outputs of the deserializer.
// No handshake: done/frame_err are single-cycle pulses with no backpressure.
interface serial_deserializer_if
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              enable;
  logic              serial_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              frame_err;
  logic              busy;

  modport master (output enable, serial_in, input data_out, done, frame_err, busy);
  modport slave  (input enable, serial_in, output data_out, done, frame_err, busy);
endinterface

// File: rtl/serial_deserializer_sync_2ff.sv
// Two-flop synchroniser with selectable reset value.
// Latency two clocks; no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_deserializer.sv
// Start/data/stop serial receiver producing LSB-first words; done lands at
// t0+2+CLKS_PER_BIT/2+(DATA_W+1)*CLKS_PER_BIT. No backpressure: pulses are fire-and-forget.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input logic                  clock,
  input logic                  reset,
  serial_deserializer_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt, timer_wrap;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, data_q;
  logic              rx_s, load;
  logic              done_q, done_nxt, ferr_q, ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.serial_in),
    .q     (rx_s)
  );

  assign timer_wrap = (timer == FULL_LAST) ? '0 : timer + TW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      idx    <= idx_nxt;
      shreg  <= shreg_nxt;
      done_q <= done_nxt;
      ferr_q <= ferr_nxt;
      if (load) data_q <= shreg;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    load      = 1'b0;
    // Dropping enable wins over any sample due this cycle, so an abort never pulses.
    if (state != IDLE && !bus.enable) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      idx_nxt   = '0;
      shreg_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && !rx_s) begin
            state_nxt = START;
            timer_nxt = '0;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer_nxt = '0;
            idx_nxt   = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        DATA: begin
          timer_nxt = timer_wrap;
          if (timer == FULL_LAST) begin
            shreg_nxt = {rx_s, shreg[DATA_W-1:1]};
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              state_nxt = STOP;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        STOP: begin
          timer_nxt = timer_wrap;
          if (timer == FULL_LAST) begin
            if (rx_s) begin
              load      = 1'b1;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
endmodule
